// File: rtl/alu_request_arbiter.sv
// Shares one ALU between requesters A and B: round-robin grant, latched operands, multi-cycle hold
// for mul/div, registered response. Optional ALU_DIVZERO_CHECK_EN short-circuits div-by-zero and flags op 7.
module alu_request_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  inpReqValidA,
  input  logic [2:0]            inpReqOpA,
  input  logic [DATA_WIDTH-1:0] inpReqSrc1A,
  input  logic [DATA_WIDTH-1:0] inpReqSrc2A,
  output logic                  outReqReadyA,
  input  logic                  inpReqValidB,
  input  logic [2:0]            inpReqOpB,
  input  logic [DATA_WIDTH-1:0] inpReqSrc1B,
  input  logic [DATA_WIDTH-1:0] inpReqSrc2B,
  output logic                  outReqReadyB,
  output logic [2:0]            outAluControl,
  output logic [DATA_WIDTH-1:0] outAluSrc1,
  output logic [DATA_WIDTH-1:0] outAluSrc2,
  input  logic [DATA_WIDTH-1:0] inpAluResult,
  input  logic                  inpAluZero,
  output logic                  outRspValid,
  output logic                  outRspId,
  output logic [DATA_WIDTH-1:0] outRspResult,
  output logic                  outRspZero,
  output logic                  outRspErr,
  input  logic                  inpRspReady,
  output logic                  outBusy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CW = (MULDIV_LATENCY < 2) ? 1 : $clog2(MULDIV_LATENCY + 1);
  localparam logic [CW-1:0] CNT_MULDIV = CW'(MULDIV_LATENCY);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

`ifdef ALU_DIVZERO_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic                    rr_ptr_q;
  logic [2:0]              op_q;
  logic [DATA_WIDTH-1:0]   src1_q, src2_q;
  logic                    id_q;
  logic                    bypass_q;
  logic [CW-1:0]           cnt_q;
  logic [DATA_WIDTH-1:0]   rsp_result_q;
  logic                    rsp_zero_q, rsp_err_q, rsp_id_q;

  logic                    grant_b, accept, done;
  logic [2:0]              win_op;
  logic [DATA_WIDTH-1:0]   win_src1, win_src2;
  logic                    win_bypass;
  logic [CW-1:0]           win_cnt;
  logic [DATA_WIDTH-1:0]   cap_result;
  logic                    cap_zero, cap_err;

  // Handshakes: a request transfers on a rising edge where valid and ready are both high; ready only
  // rises in IDLE and depends combinationally on valid. A response transfers on an edge where
  // outRspValid and inpRspReady are both high; the response fields are stable while outRspValid waits.
  always_comb begin
    grant_b      = inpReqValidB && (!inpReqValidA || rr_ptr_q);
    accept       = (state_q == IDLE) && (inpReqValidA || inpReqValidB);
    outReqReadyA = accept && !grant_b;
    outReqReadyB = accept && grant_b;
    win_op       = grant_b ? inpReqOpB   : inpReqOpA;
    win_src1     = grant_b ? inpReqSrc1B : inpReqSrc1A;
    win_src2     = grant_b ? inpReqSrc2B : inpReqSrc2A;
    win_bypass   = (win_op == 3'd7) ||
                   (CHECK_EN && (win_op == 3'd3) && (win_src2 == '0));
    win_cnt      = (!win_bypass && ((win_op == 3'd2) || (win_op == 3'd3))) ? CNT_MULDIV : CNT_ONE;
    done         = (state_q == EXEC) && (cnt_q == CNT_ONE);
  end

  // Bypassed ops never reach the ALU; their response is synthesised here.
  always_comb begin
    cap_result = inpAluResult;
    cap_zero   = inpAluZero;
    cap_err    = 1'b0;
    if (bypass_q) begin
      if (op_q == 3'd7) begin
        cap_result = '0;
        cap_zero   = 1'b1;
        cap_err    = CHECK_EN;
      end else begin
        cap_result = '1;
        cap_zero   = 1'b0;
        cap_err    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (done) state_d = RESP;
      RESP:    if (inpRspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rr_ptr_q <= 1'b0;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      id_q     <= 1'b0;
      bypass_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      rr_ptr_q <= !grant_b;
      op_q     <= win_op;
      src1_q   <= win_src1;
      src2_q   <= win_src2;
      id_q     <= grant_b;
      bypass_q <= win_bypass;
      cnt_q    <= win_cnt;
    end else if ((state_q == EXEC) && !done) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else if (done) begin
      rsp_result_q <= cap_result;
      rsp_zero_q   <= cap_zero;
      rsp_err_q    <= cap_err;
      rsp_id_q     <= id_q;
    end
  end

  always_comb begin
    outAluControl = ((state_q == EXEC) && !bypass_q) ? op_q : 3'd0;
    outAluSrc1    = (state_q == EXEC) ? src1_q : '0;
    outAluSrc2    = (state_q == EXEC) ? src2_q : '0;
    outRspValid   = (state_q == RESP);
    outRspId      = rsp_id_q;
    outRspResult  = rsp_result_q;
    outRspZero    = rsp_zero_q;
    outRspErr     = rsp_err_q;
    outBusy       = (state_q != IDLE);
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter; a behavioural ALU answers the arbiter's ALU port.
module tb_alu_request_arbiter;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic          clk, resetN;
  logic          inpReqValidA, inpReqValidB;
  logic [2:0]    inpReqOpA, inpReqOpB;
  logic [DW-1:0] inpReqSrc1A, inpReqSrc2A, inpReqSrc1B, inpReqSrc2B;
  logic          outReqReadyA, outReqReadyB;
  logic [2:0]    outAluControl;
  logic [DW-1:0] outAluSrc1, outAluSrc2, inpAluResult, outRspResult;
  logic          inpAluZero, outRspValid, outRspId, outRspZero, outRspErr;
  logic          inpRspReady, outBusy;
  logic [1:0]    dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef ALU_DIVZERO_CHECK_EN
  localparam logic EXP_ILL_ERR = 1'b1;
`else
  localparam logic EXP_ILL_ERR = 1'b0;
`endif

  alu_request_arbiter #(.DATA_WIDTH(DW), .MULDIV_LATENCY(LAT)) dut (
    .clk(clk), .resetN(resetN),
    .inpReqValidA(inpReqValidA), .inpReqOpA(inpReqOpA), .inpReqSrc1A(inpReqSrc1A),
    .inpReqSrc2A(inpReqSrc2A), .outReqReadyA(outReqReadyA),
    .inpReqValidB(inpReqValidB), .inpReqOpB(inpReqOpB), .inpReqSrc1B(inpReqSrc1B),
    .inpReqSrc2B(inpReqSrc2B), .outReqReadyB(outReqReadyB),
    .outAluControl(outAluControl), .outAluSrc1(outAluSrc1), .outAluSrc2(outAluSrc2),
    .inpAluResult(inpAluResult), .inpAluZero(inpAluZero),
    .outRspValid(outRspValid), .outRspId(outRspId), .outRspResult(outRspResult),
    .outRspZero(outRspZero), .outRspErr(outRspErr), .inpRspReady(inpRspReady),
    .outBusy(outBusy), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; division by zero answers all ones.
  always_comb begin
    case (outAluControl)
      3'd0: inpAluResult = outAluSrc1 + outAluSrc2;
      3'd1: inpAluResult = outAluSrc1 - outAluSrc2;
      3'd2: inpAluResult = outAluSrc1 * outAluSrc2;
      3'd3: inpAluResult = (outAluSrc2 == '0) ? '1 : outAluSrc1 / outAluSrc2;
      3'd4: inpAluResult = outAluSrc1 & outAluSrc2;
      3'd5: inpAluResult = outAluSrc1 | outAluSrc2;
      3'd6: inpAluResult = outAluSrc1 ^ outAluSrc2;
      default: inpAluResult = '0;
    endcase
    inpAluZero = (inpAluResult == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inpReqValidA = 0; inpReqOpA = 0; inpReqSrc1A = 0; inpReqSrc2A = 0;
    inpReqValidB = 0; inpReqOpB = 0; inpReqSrc1B = 0; inpReqSrc2B = 0;
    inpRspReady  = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2);
    inpReqValidA = 1'b1; inpReqOpA = op; inpReqSrc1A = s1; inpReqSrc2A = s2;
  endtask

  task automatic drive_b(input logic [2:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2);
    inpReqValidB = 1'b1; inpReqOpB = op; inpReqSrc1B = s1; inpReqSrc2B = s2;
  endtask

  task automatic handshake();
    inpRspReady = 1'b1;
    tick();
    inpRspReady = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetN = 1'b1;
    #1 resetN = 1'b0;
    tick();
    total_cnt++; if (outBusy !== 1'b0) $display("FAIL reset_busy: got %0h want 0", outBusy); else pass_cnt++;
    total_cnt++; if (outRspValid !== 1'b0) $display("FAIL reset_rsp_valid: got %0h want 0", outRspValid); else pass_cnt++;
    total_cnt++; if (outAluControl !== 3'd0) $display("FAIL reset_alu_ctrl: got %0h want 0", outAluControl); else pass_cnt++;
    total_cnt++; if (outRspResult !== 32'd0) $display("FAIL reset_result: got %0h want 0", outRspResult); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0h want 0", dbg_state); else pass_cnt++;
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive_a(3'd0, 32'd8, 32'd8);
    #1;
    total_cnt++; if (outReqReadyA !== 1'b1) $display("FAIL add_ready_a: got %0h want 1", outReqReadyA); else pass_cnt++;
    total_cnt++; if (outReqReadyB !== 1'b0) $display("FAIL add_ready_b: got %0h want 0", outReqReadyB); else pass_cnt++;
    tick();
    inpReqValidA = 1'b0;
    total_cnt++; if (outAluSrc1 !== 32'd8) $display("FAIL add_alu_src1: got %0h want 8", outAluSrc1); else pass_cnt++;
    total_cnt++; if (outRspValid !== 1'b0) $display("FAIL add_rsp_early: got %0h want 0", outRspValid); else pass_cnt++;
    tick();
    total_cnt++; if (outRspValid !== 1'b1) $display("FAIL add_rsp_valid: got %0h want 1", outRspValid); else pass_cnt++;
    total_cnt++; if (outRspId !== 1'b0) $display("FAIL add_rsp_id: got %0h want 0", outRspId); else pass_cnt++;
    total_cnt++; if (outRspResult !== 32'd16) $display("FAIL add_result: got %0h want 10", outRspResult); else pass_cnt++;
    total_cnt++; if (outRspZero !== 1'b0) $display("FAIL add_zero: got %0h want 0", outRspZero); else pass_cnt++;
    handshake();
    total_cnt++; if (outRspValid !== 1'b0) $display("FAIL add_rsp_drop: got %0h want 0", outRspValid); else pass_cnt++;
    total_cnt++; if (outBusy !== 1'b0) $display("FAIL add_idle: got %0h want 0", outBusy); else pass_cnt++;
  endtask

  task automatic test_mul_hold();
    drive_b(3'd2, 32'hFFFF_FFF8, 32'd4);
    #1;
    total_cnt++; if (outReqReadyB !== 1'b1) $display("FAIL mul_ready_b: got %0h want 1", outReqReadyB); else pass_cnt++;
    tick();
    inpReqValidB = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      total_cnt++; if (outAluControl !== 3'd2) $display("FAIL mul_hold_ctrl[%0d]: got %0h want 2", i, outAluControl); else pass_cnt++;
      total_cnt++; if (outAluSrc1 !== 32'hFFFF_FFF8) $display("FAIL mul_hold_src1[%0d]: got %0h want fffffff8", i, outAluSrc1); else pass_cnt++;
      total_cnt++; if (outRspValid !== 1'b0) $display("FAIL mul_hold_rsp[%0d]: got %0h want 0", i, outRspValid); else pass_cnt++;
      tick();
    end
    total_cnt++; if (outRspValid !== 1'b1) $display("FAIL mul_rsp_valid: got %0h want 1", outRspValid); else pass_cnt++;
    total_cnt++; if (outRspId !== 1'b1) $display("FAIL mul_rsp_id: got %0h want 1", outRspId); else pass_cnt++;
    total_cnt++; if (outRspResult !== 32'hFFFF_FFE0) $display("FAIL mul_result: got %0h want ffffffe0", outRspResult); else pass_cnt++;
    handshake();
  endtask

  task automatic test_round_robin();
    logic          exp_b;
    logic [DW-1:0] exp_res;
    apply_reset();
    drive_a(3'd0, 32'd1, 32'd2);
    drive_b(3'd0, 32'd10, 32'd20);
    inpRspReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b   = (k % 2) == 1;
      exp_res = exp_b ? 32'd30 : 32'd3;
      #1;
      total_cnt++; if (outReqReadyA !== !exp_b) $display("FAIL rr_ready_a[%0d]: got %0h want %0h", k, outReqReadyA, !exp_b); else pass_cnt++;
      total_cnt++; if (outReqReadyB !== exp_b) $display("FAIL rr_ready_b[%0d]: got %0h want %0h", k, outReqReadyB, exp_b); else pass_cnt++;
      tick();
      total_cnt++; if ((outReqReadyA | outReqReadyB) !== 1'b0) $display("FAIL rr_no_accept_exec[%0d]: got %0h want 0", k, outReqReadyA | outReqReadyB); else pass_cnt++;
      tick();
      total_cnt++; if (outRspId !== exp_b) $display("FAIL rr_rsp_id[%0d]: got %0h want %0h", k, outRspId, exp_b); else pass_cnt++;
      total_cnt++; if (outRspResult !== exp_res) $display("FAIL rr_result[%0d]: got %0h want %0h", k, outRspResult, exp_res); else pass_cnt++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    drive_a(3'd1, 32'd12, 32'd12);
    tick();
    inpReqValidA = 1'b0;
    drive_b(3'd0, 32'd1, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (outRspValid !== 1'b1) $display("FAIL bp_rsp_valid[%0d]: got %0h want 1", i, outRspValid); else pass_cnt++;
      total_cnt++; if (outRspResult !== 32'd0) $display("FAIL bp_result[%0d]: got %0h want 0", i, outRspResult); else pass_cnt++;
      total_cnt++; if (outRspZero !== 1'b1) $display("FAIL bp_zero[%0d]: got %0h want 1", i, outRspZero); else pass_cnt++;
      total_cnt++; if (outReqReadyB !== 1'b0) $display("FAIL bp_ready_b[%0d]: got %0h want 0", i, outReqReadyB); else pass_cnt++;
      tick();
    end
    handshake();
    total_cnt++; if (outReqReadyB !== 1'b1) $display("FAIL bp_ready_b_after: got %0h want 1", outReqReadyB); else pass_cnt++;
    inpReqValidB = 1'b0;
    tick();
    total_cnt++; if (outBusy !== 1'b0) $display("FAIL bp_drop_valid: got %0h want 0", outBusy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    drive_b(3'd3, 32'd20, 32'd5);
    tick();
    inpReqValidB = 1'b0;
    tick();
    resetN = 1'b0;
    #1;
    total_cnt++; if (outBusy !== 1'b0) $display("FAIL rst_mid_busy: got %0h want 0", outBusy); else pass_cnt++;
    total_cnt++; if (outAluControl !== 3'd0) $display("FAIL rst_mid_ctrl: got %0h want 0", outAluControl); else pass_cnt++;
    total_cnt++; if (outAluSrc1 !== 32'd0) $display("FAIL rst_mid_src1: got %0h want 0", outAluSrc1); else pass_cnt++;
    tick();
    resetN = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      total_cnt++; if (outRspValid !== 1'b0) $display("FAIL rst_mid_no_rsp[%0d]: got %0h want 0", i, outRspValid); else pass_cnt++;
    end
    // A is granted so the pointer favours B; reset must pull it back to A.
    drive_a(3'd2, 32'd3, 32'd3);
    tick();
    inpReqValidA = 1'b0;
    #2 resetN = 1'b0;
    #2 resetN = 1'b1;
    drive_a(3'd0, 32'd1, 32'd1);
    drive_b(3'd0, 32'd1, 32'd1);
    #1;
    total_cnt++; if (outReqReadyA !== 1'b1) $display("FAIL rst_mid_tie_a: got %0h want 1", outReqReadyA); else pass_cnt++;
    total_cnt++; if (outReqReadyB !== 1'b0) $display("FAIL rst_mid_tie_b: got %0h want 0", outReqReadyB); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  task automatic test_divzero();
    drive_a(3'd3, 32'd8, 32'd0);
    tick();
    inpReqValidA = 1'b0;
`ifdef ALU_DIVZERO_CHECK_EN
    total_cnt++; if (outAluControl !== 3'd0) $display("FAIL dz_ctrl: got %0h want 0", outAluControl); else pass_cnt++;
    tick();
    total_cnt++; if (outRspErr !== 1'b1) $display("FAIL dz_err: got %0h want 1", outRspErr); else pass_cnt++;
`else
    for (int i = 0; i < LAT; i++) begin
      total_cnt++; if (outAluControl !== 3'd3) $display("FAIL dz_ctrl[%0d]: got %0h want 3", i, outAluControl); else pass_cnt++;
      total_cnt++; if (outRspValid !== 1'b0) $display("FAIL dz_rsp_early[%0d]: got %0h want 0", i, outRspValid); else pass_cnt++;
      tick();
    end
    total_cnt++; if (outRspErr !== 1'b0) $display("FAIL dz_err: got %0h want 0", outRspErr); else pass_cnt++;
`endif
    total_cnt++; if (outRspValid !== 1'b1) $display("FAIL dz_rsp_valid: got %0h want 1", outRspValid); else pass_cnt++;
    total_cnt++; if (outRspResult !== 32'hFFFF_FFFF) $display("FAIL dz_result: got %0h want ffffffff", outRspResult); else pass_cnt++;
    total_cnt++; if (outRspZero !== 1'b0) $display("FAIL dz_zero: got %0h want 0", outRspZero); else pass_cnt++;
    handshake();
  endtask

  task automatic test_illegal();
    drive_b(3'd7, 32'd5, 32'd5);
    tick();
    inpReqValidB = 1'b0;
    total_cnt++; if (outAluControl !== 3'd0) $display("FAIL ill_ctrl: got %0h want 0", outAluControl); else pass_cnt++;
    total_cnt++; if (outBusy !== 1'b1) $display("FAIL ill_busy: got %0h want 1", outBusy); else pass_cnt++;
    tick();
    total_cnt++; if (outRspValid !== 1'b1) $display("FAIL ill_rsp_valid: got %0h want 1", outRspValid); else pass_cnt++;
    total_cnt++; if (outRspId !== 1'b1) $display("FAIL ill_rsp_id: got %0h want 1", outRspId); else pass_cnt++;
    total_cnt++; if (outRspResult !== 32'd0) $display("FAIL ill_result: got %0h want 0", outRspResult); else pass_cnt++;
    total_cnt++; if (outRspZero !== 1'b1) $display("FAIL ill_zero: got %0h want 1", outRspZero); else pass_cnt++;
    total_cnt++; if (outRspErr !== EXP_ILL_ERR) $display("FAIL ill_err: got %0h want %0h", outRspErr, EXP_ILL_ERR); else pass_cnt++;
    handshake();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_hold();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_divzero();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
